cpu_multicycle: RTL

- Parametrised multi-cycle successor to the team's single-cycle 16-bit CPU.
- Keeps the same 16-bit instruction format: {opcode[15:12], f1[11:8], f2[7:4], f3[3:0]}, with 16 registers.
- Generalised data width and PC width.
- Fetches and loads/stores through external ready-handshaked memories, sequenced by an FSM, so wait-states are tolerated.
- Adds SLT, JMP, HALT and an R0-is-zero rule.

---
 rtl/cpu_multicycle.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/cpu_multicycle.sv
// Multi-cycle CPU for the 16-bit {op,f1,f2,f3} ISA with ready-handshaked instruction/data memories.
// Optional: define CPU_MUL_EN to make opcode 10 a MUL (otherwise opcode 10 is a NOP).
module cpu_multicycle #(
  parameter int DW  = 16,
  parameter int PCW = 8
) (
  input  logic           clk,
  input  logic           rst,
  output logic           imem_req,
  output logic [PCW-1:0] imem_addr,
  input  logic [15:0]    imem_rdata,
  input  logic           imem_ready,
  output logic           dmem_req,
  output logic           dmem_we,
  output logic [DW-1:0]  dmem_addr,
  output logic [DW-1:0]  dmem_wdata,
  input  logic [DW-1:0]  dmem_rdata,
  input  logic           dmem_ready,
  output logic           halted,
  output logic [PCW-1:0] pc_out
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SW   = 4'd6;
  localparam logic [3:0] OP_BEQ  = 4'd7;
  localparam logic [3:0] OP_JMP  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_HALT = 4'd15;

  state_t          r_state;
  state_t          w_next;
  logic            r_run;
  logic [PCW-1:0]  r_pc;
  logic [15:0]     r_ir;
  logic [DW-1:0]   r_a;
  logic [DW-1:0]   r_b;
  logic [DW-1:0]   r_y;
  logic [DW-1:0]   r_regs [16];

  logic [3:0]      w_op;
  logic [3:0]      w_f1;
  logic [3:0]      w_f2;
  logic [3:0]      w_f3;
  logic [DW-1:0]   w_rf1;
  logic [DW-1:0]   w_rf2;
  logic [DW-1:0]   w_rf3;
  logic [DW-1:0]   w_alu;
  logic            w_fetch_go;

  assign w_op = r_ir[15:12];
  assign w_f1 = r_ir[11:8];
  assign w_f2 = r_ir[7:4];
  assign w_f3 = r_ir[3:0];

  assign w_rf1 = (w_f1 == 4'd0) ? '0 : r_regs[w_f1];
  assign w_rf2 = (w_f2 == 4'd0) ? '0 : r_regs[w_f2];
  assign w_rf3 = (w_f3 == 4'd0) ? '0 : r_regs[w_f3];

  // r_run keeps imem_req low until the first edge after reset is released.
  assign w_fetch_go = (r_state == S_FETCH) && r_run && imem_ready;

  assign imem_req   = (r_state == S_FETCH) && r_run;
  assign imem_addr  = r_pc;
  assign pc_out     = r_pc;
  assign dmem_req   = (r_state == S_MEM);
  assign dmem_we    = dmem_req && (w_op == OP_SW);
  assign dmem_addr  = dmem_req ? r_y : '0;
  assign dmem_wdata = dmem_we ? r_b : '0;
  assign halted     = (r_state == S_HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_run   <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (w_fetch_go) w_next = S_DECODE;
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        case (w_op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_SLT: w_next = S_WB;
          OP_LW, OP_SW: w_next = S_MEM;
          OP_HALT:      w_next = S_HALT;
`ifdef CPU_MUL_EN
          OP_MUL:       w_next = S_WB;
`else
          OP_MUL:       w_next = S_FETCH;
`endif
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEM:    if (dmem_ready) w_next = (w_op == OP_LW) ? S_WB : S_FETCH;
      S_WB:     w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:                w_alu = r_a + r_b;
      OP_SUB:                w_alu = r_a - r_b;
      OP_AND:                w_alu = r_a & r_b;
      OP_OR:                 w_alu = r_a | r_b;
      OP_ADDI, OP_LW, OP_SW: w_alu = r_a + DW'(w_f3);
      OP_SLT:                w_alu = ($signed(r_a) < $signed(r_b)) ? DW'(1) : '0;
`ifdef CPU_MUL_EN
      OP_MUL:                w_alu = r_a * r_b;
`endif
      default:               w_alu = '0;
    endcase
  end

  // SW and BEQ need R[f1] in B (store data / compare operand) instead of R[f3].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= '0;
      r_ir <= '0;
      r_a  <= '0;
      r_b  <= '0;
      r_y  <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_fetch_go) begin
            r_ir <= imem_rdata;
            r_pc <= r_pc + PCW'(1);
          end
        end
        S_DECODE: begin
          r_a <= w_rf2;
          r_b <= ((w_op == OP_SW) || (w_op == OP_BEQ)) ? w_rf1 : w_rf3;
        end
        S_EXEC: begin
          r_y <= w_alu;
          if ((w_op == OP_BEQ) && (r_a == r_b)) r_pc <= PCW'(w_f3);
          else if (w_op == OP_JMP) r_pc <= r_ir[PCW-1:0];
        end
        S_MEM: begin
          if (dmem_ready && (w_op == OP_LW)) r_y <= dmem_rdata;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
    end else if ((r_state == S_WB) && (w_f1 != 4'd0)) begin
      r_regs[w_f1] <= r_y;
    end
  end

endmodule
